mem_arbiter_rr: RTL and testbench

//  N-master shared-memory access arbiter.
//  - Master 0 has absolute priority and may hold memory indefinitely.
//  - Masters 1..N-1 share round-robin priority; each grant is capped at MAX_GRANT cycles.
//  - Optionally, master 0 can preempt a low-priority owner; preemptions are counted.
//  - Sits between the memory port mux and the requesting masters.

---
 rtl/mem_arbiter_rr.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr
//  Description : N-master shared-memory arbiter. Master 0 has absolute
//                priority and may hold memory until it signals done.
//                Masters 1..N-1 rotate round-robin, with each grant capped
//                at MAX_GRANT cycles. When ARB_PREEMPT_EN is defined,
//                master 0 may preempt a low-priority owner; each
//                preemption is counted in a saturating counter.
//  Macro       : ARB_PREEMPT_EN (undefined -> no preemption, counter tied 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int N_MASTERS = 3,
    parameter int MAX_GRANT = 2,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         req,
    input  logic [N_MASTERS-1:0]         done,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] grant_id,
    output logic                         busy,
    output logic                         preempted,
    output logic [CNT_W-1:0]             nb_interrupts
);

    localparam int ID_W = $clog2(N_MASTERS);
    localparam int GC_W = $clog2(MAX_GRANT + 1);

    localparam logic [GC_W-1:0] C_MAXG = GC_W'(MAX_GRANT);
    localparam logic [GC_W-1:0] C_ONE  = GC_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HP   = 2'd1;
    localparam logic [1:0] S_LP   = 2'd2;
`ifdef ARB_PREEMPT_EN
    localparam logic [1:0] S_PRE  = 2'd3;
`endif

    logic [1:0]           r_state;
    logic [ID_W-1:0]      r_grant_id;
    logic [N_MASTERS-1:0] r_grant;
    logic                 r_busy;
    logic [GC_W-1:0]      r_cnt;
    logic [ID_W-1:0]      r_rr_ptr;

    logic                 w_hit_hi;
    logic                 w_hit_lo;
    logic [ID_W-1:0]      w_win_hi;
    logic [ID_W-1:0]      w_win_lo;
    logic [ID_W-1:0]      w_win;
    logic                 w_owner_done;
    logic                 w_at_max;
    logic                 w_arb;
    logic [1:0]           w_nxt_state;
    logic [ID_W-1:0]      w_nxt_id;
    logic [GC_W-1:0]      w_nxt_cnt;
    logic [ID_W-1:0]      w_nxt_ptr;
    logic [N_MASTERS-1:0] w_nxt_grant;

    // done is only meaningful for the current owner, so mask it with the grant
    assign w_owner_done = |(done & r_grant);
    assign w_at_max     = (r_cnt == C_MAXG);

    // Round-robin search over masters 1..N-1: lowest requester at or above
    // rr_ptr wins; otherwise wrap to the lowest requester overall
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_win_hi = '0;
        w_win_lo = '0;
        for (int k = N_MASTERS - 1; k >= 1; k--) begin
            if (req[k]) begin
                w_hit_lo = 1'b1;
                w_win_lo = ID_W'(k);
                if (k >= int'(r_rr_ptr)) begin
                    w_hit_hi = 1'b1;
                    w_win_hi = ID_W'(k);
                end
            end
        end
    end

    assign w_win = w_hit_hi ? w_win_hi : w_win_lo;

`ifdef ARB_PREEMPT_EN
    logic             w_preempt;
    logic             r_preempted;
    logic [CNT_W-1:0] r_nb;
`endif

    // Next-state logic: hold/count inside a grant, arbitrate at free points
    always_comb begin
        w_arb       = 1'b0;
        w_nxt_state = r_state;
        w_nxt_id    = r_grant_id;
        w_nxt_cnt   = r_cnt;
        w_nxt_ptr   = r_rr_ptr;
`ifdef ARB_PREEMPT_EN
        w_preempt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_arb = 1'b1;
            S_HP:   w_arb = w_owner_done;
            S_LP: begin
                if (w_owner_done || w_at_max) begin
                    w_arb = 1'b1;
`ifdef ARB_PREEMPT_EN
                end else if (req[0]) begin
                    // rr_ptr already points past k since the LP grant was issued
                    w_preempt   = 1'b1;
                    w_nxt_state = S_PRE;
                    w_nxt_id    = '0;
                    w_nxt_cnt   = C_ONE;
`endif
                end else begin
                    w_nxt_cnt = r_cnt + C_ONE;
                end
            end
`ifdef ARB_PREEMPT_EN
            S_PRE: begin
                if (done[0] || w_at_max) begin
                    w_arb = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + C_ONE;
                end
            end
`endif
            default: w_arb = 1'b1;
        endcase

        if (w_arb) begin
            if (req[0]) begin
                w_nxt_state = S_HP;
                w_nxt_id    = '0;
                w_nxt_cnt   = C_ONE;
            end else if (w_hit_lo) begin
                w_nxt_state = S_LP;
                w_nxt_id    = w_win;
                w_nxt_cnt   = C_ONE;
                w_nxt_ptr   = (w_win == ID_W'(N_MASTERS - 1)) ? ID_W'(1)
                                                              : w_win + ID_W'(1);
            end else begin
                w_nxt_state = S_IDLE;
                w_nxt_id    = '0;
            end
        end

        w_nxt_grant = (w_nxt_state == S_IDLE) ? '0
                                              : (N_MASTERS'(1) << w_nxt_id);
    end

    // Arbiter state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_rr_ptr   <= ID_W'(1);
        end else begin
            r_state    <= w_nxt_state;
            r_grant_id <= w_nxt_id;
            r_grant    <= w_nxt_grant;
            r_busy     <= (w_nxt_state != S_IDLE);
            r_cnt      <= w_nxt_cnt;
            r_rr_ptr   <= w_nxt_ptr;
        end
    end

`ifdef ARB_PREEMPT_EN
    // Preemption flag and saturating preemption counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_preempted <= 1'b0;
            r_nb        <= '0;
        end else begin
            r_preempted <= (w_nxt_state == S_PRE);
            if (w_preempt && (r_nb != {CNT_W{1'b1}})) begin
                r_nb <= r_nb + CNT_W'(1);
            end
        end
    end

    assign preempted     = r_preempted;
    assign nb_interrupts = r_nb;
`else
    assign preempted     = 1'b0;
    assign nb_interrupts = '0;
`endif

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_rr
//  Description : Self-checking bench for mem_arbiter_rr (N=3, MAX_GRANT=2).
//                A cycle model pushes expected outputs into a queue as each
//                stimulus cycle is driven; they are popped and compared
//                after the clock edge. A second instance with a 2-bit
//                counter exercises saturation.
//  Macro       : ARB_PREEMPT_EN (model follows the same build option)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

    localparam int N    = 3;
    localparam int MAXG = 2;
`ifdef ARB_PREEMPT_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant,  grant_s;
    logic [1:0] gid,    gid_s;
    logic       busy,   busy_s;
    logic       pre,    pre_s;
    logic [15:0] nb;
    logic [1:0]  nb_s;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.N_MASTERS(N), .MAX_GRANT(MAXG), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .grant_id(gid), .busy(busy),
        .preempted(pre), .nb_interrupts(nb)
    );

    mem_arbiter_rr #(.N_MASTERS(N), .MAX_GRANT(MAXG), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant_s), .grant_id(gid_s), .busy(busy_s),
        .preempted(pre_s), .nb_interrupts(nb_s)
    );

    typedef struct packed {
        logic [2:0]  grant;
        logic [1:0]  id;
        logic        busy;
        logic        pre;
        logic [15:0] nb;
        logic [1:0]  nbs;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // model state: 0 idle, 1 hp, 2 lp, 3 pre
    int m_st = 0, m_own = 0, m_cnt = 0, m_ptr = 1, m_nb = 0, m_nbs = 0;

    task automatic model_arb(input logic [2:0] rq);
        bit found;
        int k;
        found = 0;
        if (rq[0]) begin
            m_st = 1; m_own = 0; m_cnt = 1;
        end else begin
            for (int i = 0; i < N - 1; i++) begin
                k = ((m_ptr - 1 + i) % (N - 1)) + 1;
                if (!found && rq[k]) begin
                    found = 1; m_st = 2; m_own = k; m_cnt = 1;
                    m_ptr = (k == N - 1) ? 1 : k + 1;
                end
            end
            if (!found) begin
                m_st = 0; m_own = 0;
            end
        end
    endtask

    task automatic model_step(input logic rst, input logic [2:0] rq, input logic [2:0] dn);
        exp_t e;
        if (rst) begin
            m_st = 0; m_own = 0; m_cnt = 0; m_ptr = 1; m_nb = 0; m_nbs = 0;
        end else begin
            case (m_st)
                0: model_arb(rq);
                1: if (dn[0]) model_arb(rq);
                2: begin
                    if (dn[m_own] || m_cnt == MAXG) model_arb(rq);
                    else if (PRE_EN && rq[0]) begin
                        m_st = 3; m_own = 0; m_cnt = 1;
                        if (m_nb  != 65535) m_nb++;
                        if (m_nbs != 3)     m_nbs++;
                    end else m_cnt++;
                end
                default: begin
                    if (dn[0] || m_cnt == MAXG) model_arb(rq);
                    else m_cnt++;
                end
            endcase
        end
        e.grant = (m_st == 0) ? 3'b000 : 3'(1 << m_own);
        e.id    = 2'(m_own);
        e.busy  = (m_st != 0);
        e.pre   = (m_st == 3);
        e.nb    = 16'(m_nb);
        e.nbs   = 2'(m_nbs);
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $error("FAIL queue: observed empty expected entry");
        end else begin
            e = q.pop_front();
            chk("grant",    16'(grant),   16'(e.grant));
            chk("grant_id", 16'(gid),     16'(e.id));
            chk("busy",     16'(busy),    16'(e.busy));
            chk("preempt",  16'(pre),     16'(e.pre));
            chk("nb_int",   nb,           e.nb);
            chk("nb_sat",   16'(nb_s),    16'(e.nbs));
            chk("grant_s",  16'(grant_s), 16'(e.grant));
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] rq, input logic [2:0] dn);
        reset = rst; req = rq; done = dn;
        model_step(rst, rq, dn);
        @(posedge clk);
        #1;
        check_out();
    endtask

    logic [2:0] rot_seq [6];

    initial begin
        reset = 1'b1; req = '0; done = '0;
        rot_seq[0] = 3'b010; rot_seq[1] = 3'b010; rot_seq[2] = 3'b100;
        rot_seq[3] = 3'b100; rot_seq[4] = 3'b010; rot_seq[5] = 3'b010;

        // reset state
        step(1, 3'b000, 3'b000);
        step(1, 3'b000, 3'b000);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_nb",    nb,         16'h0);

        // 1: sole LP requester, cap then re-grant, then release to idle
        step(0, 3'b010, 3'b000); chk("t1_c1", 16'(grant), 16'h2);
        step(0, 3'b010, 3'b000); chk("t1_c2", 16'(grant), 16'h2);
        step(0, 3'b010, 3'b000); chk("t1_c3", 16'(grant), 16'h2);
        step(0, 3'b000, 3'b000);
        step(0, 3'b000, 3'b000); chk("t1_idle", 16'(grant), 16'h0);

        // 2: round-robin rotation from rr_ptr=1
        step(1, 3'b000, 3'b000);
        for (int i = 0; i < 6; i++) begin
            step(0, 3'b110, 3'b000);
            chk("t2_rot", 16'(grant), 16'(rot_seq[i]));
        end

        // 3: master 0 requests during an LP grant
        step(1, 3'b000, 3'b000);
        step(0, 3'b010, 3'b000);
        step(0, 3'b011, 3'b000);
        chk("t3_c2", 16'(grant), PRE_EN ? 16'h1 : 16'h2);
        step(0, 3'b011, 3'b000);
        step(0, 3'b011, 3'b000);
        step(0, 3'b000, 3'b001);
        step(0, 3'b000, 3'b000);

        // 4: HP hold for 10 cycles, then back-to-back hand-over
        step(1, 3'b000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            step(0, 3'b001, 3'b000);
            chk("t4_hold", 16'(grant), 16'h1);
        end
        step(0, 3'b000, 3'b000);
        chk("t4_noreq", 16'(grant), 16'h1);
        step(0, 3'b100, 3'b001);
        chk("t4_b2b", 16'(grant), 16'h4);

        // 5: simultaneous done[1] and req[0] is a plain release
        step(1, 3'b000, 3'b000);
        step(0, 3'b010, 3'b000);
        step(0, 3'b011, 3'b010);
        chk("t5_grant", 16'(grant), 16'h1);
        chk("t5_pre",   16'(pre),   16'h0);
        step(0, 3'b000, 3'b001);

        // 6: reset mid-LP grant, then rr_ptr back at 1
        step(0, 3'b100, 3'b000);
        step(1, 3'b100, 3'b000);
        chk("t6_busy", 16'(busy), 16'h0);
        step(0, 3'b110, 3'b000);
        chk("t6_rr", 16'(grant), 16'h2);

        // repeated preemptions: saturation of the narrow counter
        step(1, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            step(0, 3'b010, 3'b000);
            step(0, 3'b011, 3'b000);
            step(0, 3'b000, 3'b001);
            step(0, 3'b000, 3'b000);
        end
        chk("sat_nb",  nb,         PRE_EN ? 16'd5 : 16'd0);
        chk("sat_nbs", 16'(nb_s),  PRE_EN ? 16'd3 : 16'd0);

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 59) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
